fifo_cmd_sequencer: RTL and testbench

Downstream consumer of the AXI-to-FIFO bridge's command FIFO. It pops 32-bit command words from a first-word-fall-through (FWFT) FIFO and decodes a 2-bit opcode in each word. Depending on the opcode, it emits the payload on an AXI-Stream master, waits a programmed number of cycles, or waits for an external trigger. Software preloads the FIFO through the bridge, then asserts `enable` to run the sequence.

---
 rtl/fifo_cmd_seq_pkg.sv | 18 +
 rtl/fifo_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_fifo_cmd_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_cmd_seq_pkg.sv
// Shared opcode constants and state encoding for the FIFO command sequencer.
// Command word layout: [DATA_WIDTH-1:DATA_WIDTH-2] opcode, [DATA_WIDTH-3:0] payload.
package fifo_cmd_seq_pkg;

   localparam logic [1:0] OP_DATA  = 2'b00;
   localparam logic [1:0] OP_DELAY = 2'b01;
   localparam logic [1:0] OP_TRIG  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StEmit,
      StDelay,
      StWaitTrig
   } state_e;

endpackage

// File: rtl/fifo_cmd_sequencer.sv
// Pops command words from an FWFT FIFO and executes them: stream a payload, wait a
// programmed number of cycles, or wait for an external trigger.
module fifo_cmd_sequencer
   import fifo_cmd_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-3:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  trigger,
   output logic                  busy,
   output logic                  underflow,
   output logic                  bad_cmd
);

   localparam int unsigned PW = DATA_WIDTH - 2;
   localparam logic [PW-1:0] CntOne = PW'(1);

   state_e        state_q, state_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d;
   logic          busy_q, busy_d;
   logic          underflow_q, underflow_d;
   logic          bad_cmd_q, bad_cmd_d;

   logic [1:0]    opcode;
   logic [PW-1:0] payload;
   logic          can_fetch;
   logic          pop;
   logic          set_underflow;
   logic          set_bad;

   // Pop is gated by reset so a reset mid-command never consumes another word.
   always_comb begin
      opcode    = fifo_rd_data[DATA_WIDTH-1 -: 2];
      payload   = fifo_rd_data[PW-1:0];
      can_fetch = (state_q == StIdle) || (state_q == StFetch);
      pop       = aresetn && can_fetch && enable && !fifo_empty;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tdata_d       = tdata_q;
      set_underflow = 1'b0;
      set_bad       = 1'b0;

      unique case (state_q)
         StIdle, StFetch: begin
            if (pop) begin
               unique case (opcode)
                  OP_DATA: begin
                     tdata_d = payload;
                     state_d = StEmit;
                  end
                  OP_DELAY: begin
                     cnt_d   = payload;
                     state_d = StDelay;
                  end
                  OP_TRIG: begin
                     state_d = StWaitTrig;
                  end
                  OP_RSVD: begin
                     set_bad = 1'b1;
                     state_d = StFetch;
                  end
               endcase
            end else if (state_q == StFetch) begin
               // Running out of words only counts as underflow while still enabled.
               set_underflow = enable && fifo_empty;
               state_d       = StIdle;
            end
         end
         StEmit: begin
            if (m_axis_tready) begin
               state_d = StFetch;
            end
         end
         StDelay: begin
            // Payload 0 and 1 both give a single DELAY cycle.
            if (cnt_q <= CntOne) begin
               state_d = StFetch;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StWaitTrig: begin
            if (trigger) begin
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      tvalid_d    = (state_d == StEmit);
      busy_d      = (state_d != StIdle);
      // A set in the same cycle as clear wins.
      underflow_d = set_underflow ? 1'b1 : (clear ? 1'b0 : underflow_q);
      bad_cmd_d   = set_bad       ? 1'b1 : (clear ? 1'b0 : bad_cmd_q);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         underflow_q <= 1'b0;
         bad_cmd_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         busy_q      <= busy_d;
         underflow_q <= underflow_d;
         bad_cmd_q   <= bad_cmd_d;
      end
   end

   assign fifo_rd_en    = pop;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign underflow     = underflow_q;
   assign bad_cmd       = bad_cmd_q;

endmodule

// File: tb/tb_fifo_cmd_sequencer.sv
// Self-checking bench for fifo_cmd_sequencer: directed timing scenarios plus a randomized
// command program checked against pop-to-pop timing rules and the expected beat sequence.
module tb_fifo_cmd_sequencer;

   localparam int unsigned DW = 32;
   localparam int unsigned PW = DW - 2;
   localparam logic [1:0] OpData  = 2'b00;
   localparam logic [1:0] OpDelay = 2'b01;
   localparam logic [1:0] OpTrig  = 2'b10;
   localparam logic [1:0] OpRsvd  = 2'b11;
   localparam int unsigned NumRnd = 40;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          enable;
   logic          clear;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [PW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          trigger;
   logic          busy;
   logic          underflow;
   logic          bad_cmd;

   always #5 aclk = ~aclk;

   fifo_cmd_sequencer #(
      .DATA_WIDTH (DW)
   ) u_dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .enable        (enable),
      .clear         (clear),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .trigger       (trigger),
      .busy          (busy),
      .underflow     (underflow),
      .bad_cmd       (bad_cmd)
   );

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] pop_word[$];
   logic [DW-1:0] gen[$];
   logic [PW-1:0] beat_data[$];
   logic [PW-1:0] exp_beats[$];
   int            pop_cyc[$];
   int            beat_cyc[$];
   int            trig_cyc[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   logic          prev_stall = 1'b0;
   logic [PW-1:0] prev_tdata = '0;
   int            dly[3] = '{10, 0, 1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] cmd(input logic [1:0] op, input logic [PW-1:0] p);
      return {op, p};
   endfunction

   task automatic refresh_fifo();
      fifo_empty   = (fifo_q.size() == 0);
      fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      refresh_fifo();
   endtask

   // Sample the current cycle just after inputs settle, then advance to the next negedge.
   task automatic tick();
      logic popped;
      #1;
      popped = fifo_rd_en && (fifo_q.size() > 0);
      if (fifo_rd_en) begin
         check("rd_en_when_empty", 64'(fifo_empty), 64'd0);
      end
      if (popped) begin
         pop_cyc.push_back(cyc);
         pop_word.push_back(fifo_q[0]);
      end
      if (m_axis_tvalid && m_axis_tready) begin
         beat_cyc.push_back(cyc);
         beat_data.push_back(m_axis_tdata);
      end
      if (prev_stall && m_axis_tvalid) begin
         check("tdata_stable", 64'(m_axis_tdata), 64'(prev_tdata));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_tdata = m_axis_tdata;
      if (trigger) trig_cyc.push_back(cyc);
      @(negedge aclk);
      if (popped) void'(fifo_q.pop_front());
      refresh_fifo();
      cyc++;
   endtask

   task automatic do_reset();
      aresetn       = 1'b0;
      enable        = 1'b0;
      clear         = 1'b0;
      trigger       = 1'b0;
      m_axis_tready = 1'b0;
      fifo_q.delete();
      refresh_fifo();
      tick();
      tick();
      aresetn = 1'b1;
      pop_cyc.delete();
      pop_word.delete();
      beat_cyc.delete();
      beat_data.delete();
      trig_cyc.delete();
      prev_stall = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int m;
      int nxt;
      int k;
      logic [31:0] r32;
      logic [PW-1:0] p;
      logic [1:0] op;
      logic exp_bad;

      // Reset state, with a word present and enable high to prove no pop under reset.
      aresetn       = 1'b0;
      enable        = 1'b1;
      clear         = 1'b0;
      trigger       = 1'b0;
      m_axis_tready = 1'b0;
      refresh_fifo();
      push(cmd(OpData, PW'('h3FF)));
      @(negedge aclk);
      tick();
      tick();
      check("rst_rd_en",     64'(fifo_rd_en),    64'd0);
      check("rst_tvalid",    64'(m_axis_tvalid), 64'd0);
      check("rst_tdata",     64'(m_axis_tdata),  64'd0);
      check("rst_busy",      64'(busy),          64'd0);
      check("rst_underflow", 64'(underflow),     64'd0);
      check("rst_bad_cmd",   64'(bad_cmd),       64'd0);

      // Two back-to-back DATA words, then underflow on the empty FETCH.
      do_reset();
      push(cmd(OpData, PW'('h123)));
      push(cmd(OpData, PW'('h456)));
      m_axis_tready = 1'b1;
      enable        = 1'b1;
      repeat (10) tick();
      check("t1_beats", 64'(beat_data.size()), 64'd2);
      if (beat_data.size() >= 2) begin
         check("t1_beat0", 64'(beat_data[0]), 64'h123);
         check("t1_beat1", 64'(beat_data[1]), 64'h456);
         check("t1_gap",   64'(beat_cyc[1] - beat_cyc[0]), 64'd2);
      end
      check("t1_underflow", 64'(underflow), 64'd1);
      check("t1_busy",      64'(busy),      64'd0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t1_clear", 64'(underflow), 64'd0);

      // Backpressure: payload held for 5 stalled cycles, exactly one beat.
      do_reset();
      push(cmd(OpData, PW'('hABC)));
      enable = 1'b1;
      tick();
      repeat (5) begin
         check("t2_tvalid", 64'(m_axis_tvalid), 64'd1);
         check("t2_tdata",  64'(m_axis_tdata),  64'hABC);
         tick();
      end
      m_axis_tready = 1'b1;
      repeat (5) tick();
      check("t2_beats", 64'(beat_data.size()), 64'd1);

      // DELAY timing: tvalid rises max(P,1)+2 cycles after the DELAY pop.
      for (int i = 0; i < 3; i++) begin
         do_reset();
         push(cmd(OpDelay, PW'(dly[i])));
         push(cmd(OpData, PW'(1)));
         enable        = 1'b1;
         m_axis_tready = 1'b1;
         repeat (dly[i] + 8) tick();
         check("t3_beats", 64'(beat_data.size()), 64'd1);
         check("t3_pops",  64'(pop_cyc.size()),   64'd2);
         if (beat_cyc.size() >= 1 && pop_cyc.size() >= 2) begin
            check("t3_tvalid_lat", 64'(beat_cyc[0] - pop_cyc[0]),
                  64'(((dly[i] == 0) ? 1 : dly[i]) + 2));
            check("t3_pop_gap", 64'(pop_cyc[1] - pop_cyc[0]),
                  64'(((dly[i] == 0) ? 1 : dly[i]) + 1));
         end
      end

      // TRIG: nothing until the pulse, tvalid two cycles after it.
      do_reset();
      push(cmd(OpTrig, '0));
      push(cmd(OpData, PW'(7)));
      enable        = 1'b1;
      m_axis_tready = 1'b1;
      tick();
      repeat (19) tick();
      check("t4_no_early_beat", 64'(beat_data.size()), 64'd0);
      m       = cyc;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      repeat (4) tick();
      check("t4_beats", 64'(beat_data.size()), 64'd1);
      if (beat_cyc.size() >= 1) begin
         check("t4_lat",  64'(beat_cyc[0] - m), 64'd2);
         check("t4_data", 64'(beat_data[0]),    64'd7);
      end

      // Reserved opcode, clear, and set-wins-over-clear.
      do_reset();
      push(32'hC000_0005);
      push(cmd(OpData, PW'(2)));
      enable        = 1'b1;
      m_axis_tready = 1'b1;
      repeat (8) tick();
      check("t5_bad_cmd", 64'(bad_cmd),          64'd1);
      check("t5_beats",   64'(beat_data.size()), 64'd1);
      if (beat_data.size() >= 1) check("t5_data", 64'(beat_data[0]), 64'd2);
      enable = 1'b0;
      clear  = 1'b1;
      tick();
      clear = 1'b0;
      check("t5_clear", 64'(bad_cmd), 64'd0);
      push(32'hC000_0005);
      enable = 1'b1;
      clear  = 1'b1;
      tick();
      clear = 1'b0;
      check("t5_set_wins", 64'(bad_cmd),        64'd1);
      check("t5_pops",     64'(pop_cyc.size()), 64'd3);

      // Drop enable mid-delay: delay completes, back to IDLE without popping.
      do_reset();
      push(cmd(OpDelay, PW'(50)));
      push(cmd(OpData, PW'(9)));
      enable        = 1'b1;
      m_axis_tready = 1'b1;
      repeat (21) tick();
      check("t6_busy_mid", 64'(busy), 64'd1);
      enable = 1'b0;
      repeat (40) tick();
      check("t6_pops",      64'(pop_cyc.size()),   64'd1);
      check("t6_busy",      64'(busy),             64'd0);
      check("t6_underflow", 64'(underflow),        64'd0);
      check("t6_no_beat",   64'(beat_data.size()), 64'd0);
      enable = 1'b1;
      repeat (4) tick();
      check("t6_resume", 64'(beat_data.size()), 64'd1);
      if (beat_data.size() >= 1) check("t6_data", 64'(beat_data[0]), 64'd9);

      // Reset while in EMIT.
      do_reset();
      push(cmd(OpData, PW'('h55)));
      enable = 1'b1;
      tick();
      check("t7_in_emit", 64'(m_axis_tvalid), 64'd1);
      push(cmd(OpData, PW'('h66)));
      aresetn = 1'b0;
      tick();
      check("t7_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t7_busy",   64'(busy),          64'd0);
      check("t7_tdata",  64'(m_axis_tdata),  64'd0);
      check("t7_rd_en",  64'(fifo_rd_en),    64'd0);
      aresetn = 1'b1;
      enable  = 1'b0;
      tick();
      check("t7_pops", 64'(pop_cyc.size()), 64'd1);
      enable = 1'b1;
      tick();
      check("t7_idle_pop", 64'(pop_cyc.size()), 64'd2);

      // Randomized program with random backpressure and triggers.
      do_reset();
      gen.delete();
      exp_beats.delete();
      exp_bad = 1'b0;
      for (int i = 0; i < NumRnd; i++) begin
         r32 = $urandom();
         p   = r32[PW-1:0];
         k   = $urandom_range(0, 9);
         if (k < 5) begin
            op = OpData;
            exp_beats.push_back(p);
         end else if (k < 7) begin
            op = OpDelay;
            p  = PW'($urandom_range(0, 6));
         end else if (k < 9) begin
            op = OpTrig;
         end else begin
            op      = OpRsvd;
            exp_bad = 1'b1;
         end
         gen.push_back(cmd(op, p));
         push(cmd(op, p));
      end
      enable = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (pop_cyc.size() == NumRnd && !busy) break;
         m_axis_tready = ($urandom_range(0, 9) < 6);
         trigger       = ($urandom_range(0, 4) == 0);
         tick();
      end
      trigger = 1'b0;
      check("rnd_all_popped", 64'(pop_cyc.size()), 64'(NumRnd));
      check("rnd_busy",       64'(busy),           64'd0);
      check("rnd_underflow",  64'(underflow),      64'd1);
      check("rnd_bad_cmd",    64'(bad_cmd),        64'(exp_bad));
      check("rnd_beat_count", 64'(beat_data.size()), 64'(exp_beats.size()));
      for (int i = 0; i < exp_beats.size() && i < beat_data.size(); i++) begin
         check("rnd_beat", 64'(beat_data[i]), 64'(exp_beats[i]));
      end
      k = 0;
      for (int i = 0; i + 1 < pop_cyc.size(); i++) begin
         op  = gen[i][DW-1:DW-2];
         p   = gen[i][PW-1:0];
         nxt = -1;
         if (op == OpData) begin
            if (k < beat_cyc.size()) nxt = beat_cyc[k] + 1;
            k++;
         end else if (op == OpDelay) begin
            nxt = pop_cyc[i] + ((p == '0) ? 1 : int'(p)) + 1;
         end else if (op == OpTrig) begin
            foreach (trig_cyc[j]) begin
               if (nxt < 0 && trig_cyc[j] > pop_cyc[i]) nxt = trig_cyc[j] + 1;
            end
         end else begin
            nxt = pop_cyc[i] + 1;
         end
         check("rnd_pop_timing", 64'(pop_cyc[i+1]), 64'(nxt));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
